// File: rtl/ifu_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch_pkg
// Description : Shared miniRV constants and the fetch-stage state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ILEN       = 32;
  localparam int unsigned INSN_BYTES = 4;

  // Must match the reset value of the PC register.
  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } ifu_state_t;

endpackage : ifu_fetch_pkg
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch
// Description : miniRV instruction fetch: next-PC select, one-deep imem
//               request/response sequencing and decode hand-off.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
  parameter int unsigned         XLEN       = ifu_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0]     INITIAL_PC = ifu_fetch_pkg::RESET_PC
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc_addr,
  output logic [XLEN-1:0] next_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  output logic            resp_ready,
  input  logic [31:0]     resp_data,
  input  logic            resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault
);

  import ifu_fetch_pkg::ifu_state_t;
  import ifu_fetch_pkg::S_IDLE;
  import ifu_fetch_pkg::S_REQ;
  import ifu_fetch_pkg::S_WAIT;
  import ifu_fetch_pkg::S_HOLD;
  import ifu_fetch_pkg::INSN_BYTES;

  localparam logic [XLEN-1:0] C_STEP = XLEN'(INSN_BYTES);

  ifu_state_t      state_q;
  logic            kill_q;
  logic [XLEN-1:0] req_addr_q;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic            fault_q;
  logic [XLEN-1:0] next_pc_d;

  // Targets are forced word-aligned; the dropped low bits are intentionally ignored.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    next_pc_d = pc_addr;
    if (redirect_valid) begin
      next_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if ((state_q == S_HOLD) && inst_ready) begin
      next_pc_d = pc_addr + C_STEP;
    end
  end

  assign next_pc    = next_pc_d;
  assign req_valid  = (state_q == S_REQ);
  assign resp_ready = (state_q == S_WAIT);
  assign inst_valid = (state_q == S_HOLD);
  assign req_addr   = req_addr_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = fault_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      kill_q     <= 1'b0;
      req_addr_q <= INITIAL_PC;
      inst_q     <= 32'h0;
      inst_pc_q  <= INITIAL_PC;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q    <= S_REQ;
          req_addr_q <= next_pc_d;
        end
        S_REQ: begin
          // A posted request cannot be withdrawn, so a redirect only marks it stale.
          if (redirect_valid) begin
            kill_q <= 1'b1;
          end
          if (req_ready) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (resp_valid) begin
            if (kill_q || redirect_valid) begin
              kill_q     <= 1'b0;
              state_q    <= S_REQ;
              req_addr_q <= next_pc_d;
            end else begin
              inst_q    <= resp_data;
              inst_pc_q <= req_addr_q;
              fault_q   <= resp_err;
              state_q   <= S_HOLD;
            end
          end else if (redirect_valid) begin
            kill_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid || inst_ready) begin
            state_q    <= S_REQ;
            req_addr_q <= next_pc_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule : ifu_fetch
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch
// Description : Directed scoreboard bench for ifu_fetch with a PC register model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

  localparam logic [31:0] INIT = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc_addr;
  logic [31:0] next_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  logic [64:0] exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // PC register that the fetch stage sits around.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_addr <= INIT;
    else          pc_addr <= next_pc;
  end

  ifu_fetch #(.XLEN(32), .INITIAL_PC(INIT)) dut (
    .clock(clk), .reset_n(reset_n), .pc_addr(pc_addr), .next_pc(next_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault)
  );

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!req_valid && n < 20) begin tick(); n++; end
    chk(nm, {95'b0, req_valid}, 96'd1);
  endtask

  task automatic wait_inst(input string nm);
    int n = 0;
    while (!inst_valid && n < 20) begin tick(); n++; end
    chk(nm, {95'b0, inst_valid}, 96'd1);
  endtask

  task automatic do_reset();
    chk("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_data = 32'h0; resp_err = 1'b0;
    inst_ready = 1'b0;
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  // Monitor: each new instruction presented to decode is matched against the queue.
  initial begin
    logic prev_v = 1'b0;
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_v = 1'b0;
      end else begin
        if (inst_valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_inst: got inst=%h pc=%h fault=%b, required no instruction",
                     inst, inst_pc, inst_fault);
          end else begin
            e = exp_q.pop_front();
            chk("inst_word_pc_fault", {31'b0, inst, inst_pc, inst_fault}, {31'b0, e});
          end
        end
        prev_v = inst_valid;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t[3];
    reset_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_data = 32'h0; resp_err = 1'b0;
    inst_ready = 1'b0;
    repeat (3) tick();

    chk("rst_req_valid",  req_valid,  0);
    chk("rst_resp_ready", resp_ready, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst",       inst,       0);
    chk("rst_inst_pc",    inst_pc,    INIT);
    chk("rst_inst_fault", inst_fault, 0);
    chk("rst_req_addr",   req_addr,   INIT);
    chk("rst_next_pc",    next_pc,    INIT);
    reset_n = 1'b1;

    // Streaming: zero-wait memory and decode.
    req_ready = 1'b1; resp_valid = 1'b1; resp_data = 32'h0000_0013; inst_ready = 1'b1;
    exp_q.push_back({32'h0000_0013, INIT,               1'b0});
    exp_q.push_back({32'h0000_0013, INIT + 32'd4,       1'b0});
    exp_q.push_back({32'h0000_0013, INIT + 32'd8,       1'b0});
    for (int k = 0; k < 3; k++) begin
      wait_req("stream_req_seen");
      chk("stream_req_addr", req_addr, INIT + 32'(4 * k));
      t[k] = cyc;
      tick();
    end
    chk("stream_period_a", t[1] - t[0], 3);
    chk("stream_period_b", t[2] - t[1], 3);
    tick();
    resp_valid = 1'b0;
    tick(); tick();

    // Back-pressure on the request channel.
    do_reset();
    wait_req("stall_req_seen");
    for (int k = 0; k < 5; k++) begin
      chk("stall_req_valid", req_valid, 1);
      chk("stall_req_addr",  req_addr,  INIT);
      chk("stall_next_pc",   next_pc,   INIT);
      tick();
    end
    req_ready = 1'b1; resp_valid = 1'b1; resp_data = 32'h0010_0093;
    exp_q.push_back({32'h0010_0093, INIT, 1'b0});
    wait_inst("stall_inst_seen");
    resp_valid = 1'b0; inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    tick();

    // Redirect while the response is outstanding.
    do_reset();
    req_ready = 1'b1; inst_ready = 1'b1;
    wait_req("wait_redir_req_seen");
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
    #1;
    chk("wait_redir_next_pc", next_pc, 32'h8000_0100);
    tick();
    redirect_valid = 1'b0; resp_valid = 1'b1; resp_data = 32'h0BAD_0BAD;
    tick();
    chk("wait_redir_inst_valid", inst_valid, 0);
    chk("wait_redir_req_valid",  req_valid,  1);
    chk("wait_redir_req_addr",   req_addr,   32'h8000_0100);
    resp_data = 32'h0050_0113;
    exp_q.push_back({32'h0050_0113, 32'h8000_0100, 1'b0});
    wait_inst("wait_redir_inst_seen");
    resp_valid = 1'b0;
    tick();
    inst_ready = 1'b0;
    tick();

    // Redirect coincident with decode accepting the held instruction.
    do_reset();
    req_ready = 1'b1; resp_valid = 1'b1; resp_data = 32'h0000_0297;
    exp_q.push_back({32'h0000_0297, INIT, 1'b0});
    wait_inst("hold_redir_inst_seen");
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    #1;
    chk("hold_redir_next_pc", next_pc, 32'h8000_0200);
    tick();
    chk("hold_redir_inst_valid", inst_valid, 0);
    chk("hold_redir_req_addr",   req_addr,   32'h8000_0200);
    redirect_valid = 1'b0; resp_valid = 1'b0; inst_ready = 1'b0;
    tick();

    // Bus error is passed through and held.
    do_reset();
    req_ready = 1'b1; resp_valid = 1'b1; resp_err = 1'b1; resp_data = 32'hDEAD_BEEF;
    exp_q.push_back({32'hDEAD_BEEF, INIT, 1'b1});
    wait_inst("err_inst_seen");
    resp_valid = 1'b0; resp_err = 1'b0; resp_data = 32'h0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("err_hold_valid", inst_valid, 1);
      chk("err_hold_inst",  inst,       32'hDEAD_BEEF);
      chk("err_hold_fault", inst_fault, 1);
    end
    inst_ready = 1'b1;
    tick();
    chk("err_released", inst_valid, 0);
    inst_ready = 1'b0;

    // PC wrap at the top of the address space.
    do_reset();
    req_ready = 1'b1;
    wait_req("wrap_req_seen");
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0; resp_valid = 1'b1; resp_data = 32'h0000_0001;
    tick();
    chk("wrap_req_addr_top", req_addr, 32'hFFFF_FFFC);
    resp_data = 32'h0000_0073;
    exp_q.push_back({32'h0000_0073, 32'hFFFF_FFFC, 1'b0});
    wait_inst("wrap_inst_seen");
    inst_ready = 1'b1;
    #1;
    chk("wrap_next_pc", next_pc, 32'h0000_0000);
    tick();
    chk("wrap_req_addr_zero", req_addr, 32'h0000_0000);
    resp_valid = 1'b0; inst_ready = 1'b0;
    tick();

    // Asynchronous reset in the middle of a transaction.
    do_reset();
    req_ready = 1'b1;
    wait_req("arst_req_seen");
    tick();
    chk("arst_in_wait", resp_ready, 1);
    resp_valid = 1'b1; resp_data = 32'h1234_5678;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_req_valid",  req_valid,  0);
    chk("arst_resp_ready", resp_ready, 0);
    chk("arst_inst_valid", inst_valid, 0);
    chk("arst_req_addr",   req_addr,   INIT);
    chk("arst_inst_pc",    inst_pc,    INIT);
    chk("arst_next_pc",    next_pc,    INIT);
    tick();
    chk("arst_late_resp", inst_valid, 0);
    resp_valid = 1'b0;
    reset_n = 1'b1;
    tick(); tick();

    chk("scoreboard_final", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_ifu_fetch
`default_nettype wire
